// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch / data access) for a single-ported memory.
// Round-robin on ties; registers the granted request and sequences read latency.
//   state | meaning
//   IDLE  | waiting for if_req / dm_req, grant on request
//   ISSUE | one-cycle memory strobe with registered address/data
//   WAIT  | counting down the memory read latency, capture on terminal count
//   ACK   | one-cycle acknowledge to the granted requester
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t           state;
  logic [CNT_W-1:0] lat_cnt;
  logic             we_q;
  logic             last_owner;
  logic             grant_dm;

  // Data wins when it is the only requester, or on a tie when fetch was granted last.
  assign grant_dm = dm_req & (~if_req | ~last_owner);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      we_q       <= 1'b0;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      busy       <= 1'b0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            owner      <= grant_dm;
            last_owner <= grant_dm;
            mem_addr   <= grant_dm ? dm_addr : if_addr;
            if (grant_dm) mem_wdata <= dm_wdata;
            we_q       <= grant_dm & dm_we;
            mem_re     <= ~(grant_dm & dm_we);
            mem_we     <= grant_dm & dm_we;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            dm_ack <= 1'b1;
            state  <= ACK;
          end else begin
            lat_cnt <= CNT_W'(MEM_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          // Terminal count lines up with the cycle in which mem_rdata is valid.
          if (lat_cnt == '0) begin
            if (owner) dm_rdata <= mem_rdata;
            else       if_rdata <= mem_rdata[31:0];
            if_ack <= ~owner;
            dm_ack <= owner;
            state  <= ACK;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: one instance at MEM_LAT=2, one at MEM_LAT=1,
// each with a small behavioral memory; acks are checked against a scoreboard of expected results.
module tb_mem_port_arbiter;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // DUT A (MEM_LAT=2)
  logic        a_if_req, a_if_ack, a_dm_req, a_dm_we, a_dm_ack;
  logic [31:0] a_if_addr, a_dm_addr, a_mem_addr, a_if_rdata;
  logic [63:0] a_dm_wdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_mem_re, a_mem_we, a_busy, a_owner;
  // DUT B (MEM_LAT=1)
  logic        b_if_req, b_if_ack, b_dm_req, b_dm_we, b_dm_ack;
  logic [31:0] b_if_addr, b_dm_addr, b_mem_addr, b_if_rdata;
  logic [63:0] b_dm_wdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_mem_re, b_mem_we, b_busy, b_owner;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(2)) dut_a (
    .CLK(CLK), .RST_N(RST_N),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_ack(a_dm_ack), .dm_rdata(a_dm_rdata),
    .mem_re(a_mem_re), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(1)) dut_b (
    .CLK(CLK), .RST_N(RST_N),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
    .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner));

  function automatic logic [63:0] preset(input int i);
    case (i)
      0:       preset = 64'hAAAA_BBBB_0010_0113;
      2:       preset = 64'h1111_2222_0050_0093;
      3:       preset = 64'h3333_4444_0000_0073;
      8:       preset = 64'h0123_4567_89AB_CDEF;
      9:       preset = 64'hFEDC_BA98_7654_3210;
      10:      preset = 64'h0F0F_1234_5678_F0F0;
      default: preset = {32'hC0DE_0000 + 32'(i), 32'h6000_0000 + 32'(i)};
    endcase
  endfunction

  function automatic logic [63:0] preset_at(input logic [31:0] addr);
    preset_at = preset(int'(addr[7:3]));
  endfunction

  // Behavioral memories: data valid MEM_LAT cycles after the mem_re cycle
  logic [63:0] mem_a [0:31];
  logic [63:0] mem_b [0:31];
  logic [63:0] a_d0, a_d1, b_d0;

  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 32; i++) mem_a[i] <= preset(i);
    end else if (a_mem_we) begin
      mem_a[a_mem_addr[7:3]] <= a_mem_wdata;
    end
    a_d0 <= a_mem_re ? mem_a[a_mem_addr[7:3]] : 64'h5555_5555_5555_5555;
    a_d1 <= a_d0;
  end
  assign a_mem_rdata = a_d1;

  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 32; i++) mem_b[i] <= preset(i);
    end else if (b_mem_we) begin
      mem_b[b_mem_addr[7:3]] <= b_mem_wdata;
    end
    b_d0 <= b_mem_re ? mem_b[b_mem_addr[7:3]] : 64'h5555_5555_5555_5555;
  end
  assign b_mem_rdata = b_d0;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } vec_t;

  exp_t a_if_q[$], a_dm_q[$], b_if_q[$], b_dm_q[$];
  bit a_if_ack_seen, a_dm_ack_seen, b_if_ack_seen, b_dm_ack_seen;
  logic [63:0] a_last_dm, b_last_dm;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_line(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: event seen, none expected (cycle %0d)", name, cyc);
  endtask

  task automatic monitor();
    exp_t e;
    a_if_ack_seen = a_if_ack;
    a_dm_ack_seen = a_dm_ack;
    b_if_ack_seen = b_if_ack;
    b_dm_ack_seen = b_dm_ack;
    if (a_mem_re || a_mem_we) chk("a_strobe_excl", 64'(a_mem_re & a_mem_we), 64'd0);
    if (b_mem_re || b_mem_we) chk("b_strobe_excl", 64'(b_mem_re & b_mem_we), 64'd0);
    if (a_if_ack) begin
      if (a_if_q.size() == 0) fail_line("a_if_unexpected_ack");
      else begin
        e = a_if_q.pop_front();
        chk("a_if_rdata", 64'(a_if_rdata), 64'(e.data[31:0]));
        chk("a_if_ack_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
    if (a_dm_ack) begin
      if (a_dm_q.size() == 0) fail_line("a_dm_unexpected_ack");
      else begin
        e = a_dm_q.pop_front();
        chk("a_dm_rdata", a_dm_rdata, e.data);
        chk("a_dm_ack_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
    if (b_if_ack) begin
      if (b_if_q.size() == 0) fail_line("b_if_unexpected_ack");
      else begin
        e = b_if_q.pop_front();
        chk("b_if_rdata", 64'(b_if_rdata), 64'(e.data[31:0]));
        chk("b_if_ack_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
    if (b_dm_ack) begin
      if (b_dm_q.size() == 0) fail_line("b_dm_unexpected_ack");
      else begin
        e = b_dm_q.pop_front();
        chk("b_dm_rdata", b_dm_rdata, e.data);
        chk("b_dm_ack_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
  endtask

  task automatic step();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit on_b, input bit port, input bit req, input bit we,
                       input logic [31:0] addr, input logic [63:0] wdata);
    if (!on_b) begin
      if (!port) begin
        a_if_req = req;
        if (req) a_if_addr = addr;
      end else begin
        a_dm_req = req;
        if (req) begin a_dm_we = we; a_dm_addr = addr; a_dm_wdata = wdata; end
      end
    end else begin
      if (!port) begin
        b_if_req = req;
        if (req) b_if_addr = addr;
      end else begin
        b_dm_req = req;
        if (req) begin b_dm_we = we; b_dm_addr = addr; b_dm_wdata = wdata; end
      end
    end
  endtask

  task automatic push(input bit on_b, input bit port, input exp_t e);
    case ({on_b, port})
      2'b00: a_if_q.push_back(e);
      2'b01: a_dm_q.push_back(e);
      2'b10: b_if_q.push_back(e);
      default: b_dm_q.push_back(e);
    endcase
  endtask

  task automatic chk_rst(input bit on_b, input string tag);
    if (!on_b) begin
      chk({tag, "_flags"}, 64'({a_if_ack, a_dm_ack, a_mem_re, a_mem_we, a_busy, a_owner}), 64'd0);
      chk({tag, "_mem_addr"}, 64'(a_mem_addr), 64'd0);
      chk({tag, "_mem_wdata"}, a_mem_wdata, 64'd0);
      chk({tag, "_if_rdata"}, 64'(a_if_rdata), 64'd0);
      chk({tag, "_dm_rdata"}, a_dm_rdata, 64'd0);
    end else begin
      chk({tag, "_flags"}, 64'({b_if_ack, b_dm_ack, b_mem_re, b_mem_we, b_busy, b_owner}), 64'd0);
      chk({tag, "_mem_addr"}, 64'(b_mem_addr), 64'd0);
      chk({tag, "_dm_rdata"}, b_dm_rdata, 64'd0);
    end
  endtask

  // Single isolated transaction; lat is the ack cycle relative to the sampling cycle.
  task automatic run_txn(input bit on_b, input bit port, input bit we, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [63:0] exp, input int lat);
    exp_t e;
    bit   got;
    drive(on_b, port, 1'b1, we, addr, wdata);
    e.data = exp;
    e.cyc  = cyc + lat;
    push(on_b, port, e);
    step();
    chk("issue_re", 64'(on_b ? b_mem_re : a_mem_re), 64'(!we));
    chk("issue_we", 64'(on_b ? b_mem_we : a_mem_we), 64'(we));
    chk("issue_addr", 64'(on_b ? b_mem_addr : a_mem_addr), 64'(addr));
    chk("issue_owner", 64'(on_b ? b_owner : a_owner), 64'(port));
    if (we) chk("issue_wdata", on_b ? b_mem_wdata : a_mem_wdata, wdata);
    drive(on_b, port, 1'b1, we, addr ^ 32'h40, ~wdata);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      chk("txn_busy", 64'(on_b ? b_busy : a_busy), 64'd1);
      step();
      got = on_b ? (port ? b_dm_ack_seen : b_if_ack_seen) : (port ? a_dm_ack_seen : a_if_ack_seen);
    end
    if (!got) fail_line("txn_ack_timeout");
    drive(on_b, port, 1'b0, 1'b0, 32'd0, 64'd0);
    chk("txn_addr_hold", 64'(on_b ? b_mem_addr : a_mem_addr), 64'(addr));
    if (we) chk("txn_wdata_hold", on_b ? b_mem_wdata : a_mem_wdata, wdata);
    chk("idle_after_ack", 64'(on_b ? b_busy : a_busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[8];
    vec_t        v;
    exp_t        e;
    logic [31:0] f_addr[3];
    logic [31:0] d_addr[3];
    int          c0, fj, dj, fdone, ddone, sidx;

    vecs[0] = '{1'b0, 1'b0, 32'h10, 64'd0, 64'h1111_2222_0050_0093};
    vecs[1] = '{1'b1, 1'b1, 32'h80, 64'hDEAD_BEEF_CAFE_F00D, 64'd0};
    vecs[2] = '{1'b1, 1'b0, 32'h80, 64'd0, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[3] = '{1'b0, 1'b0, 32'h80, 64'd0, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[4] = '{1'b1, 1'b1, 32'h88, 64'h0000_0001_8000_0000, 64'd0};
    vecs[5] = '{1'b1, 1'b0, 32'h48, 64'd0, 64'hFEDC_BA98_7654_3210};
    vecs[6] = '{1'b1, 1'b0, 32'h88, 64'd0, 64'h0000_0001_8000_0000};
    vecs[7] = '{1'b0, 1'b0, 32'h18, 64'd0, 64'h3333_4444_0000_0073};
    f_addr[0] = 32'h00; f_addr[1] = 32'h10; f_addr[2] = 32'h18;
    d_addr[0] = 32'h40; d_addr[1] = 32'h48; d_addr[2] = 32'h50;

    RST_N = 1'b0;
    a_if_req = 0; a_if_addr = 0; a_dm_req = 0; a_dm_we = 0; a_dm_addr = 0; a_dm_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = 0; b_dm_wdata = 0;
    repeat (3) step();
    chk_rst(1'b0, "reset_a");
    chk_rst(1'b1, "reset_b");
    RST_N = 1'b1;
    step();

    // Continuous contention from reset: grants must go F,D,F,D,F,D, 5 cycles per read
    fj = 0; dj = 0; fdone = 0; ddone = 0; sidx = 0;
    c0 = cyc;
    drive(1'b0, 1'b0, 1'b1, 1'b0, f_addr[0], 64'd0);
    e.data = preset_at(f_addr[0]); e.cyc = c0 + 4; push(1'b0, 1'b0, e); fj = 1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, d_addr[0], 64'd0);
    e.data = preset_at(d_addr[0]); e.cyc = c0 + 9; push(1'b0, 1'b1, e); dj = 1;
    for (int t = 0; t < 60 && (fdone < 3 || ddone < 3); t++) begin
      step();
      if (a_mem_re || a_mem_we) begin
        chk("cont_owner", 64'(a_owner), 64'(sidx % 2));
        chk("cont_issue_cyc", 64'(cyc), 64'(c0 + 1 + 5 * sidx));
        sidx++;
      end
      if (a_if_ack_seen) begin
        a_if_req = 1'b0;
        fdone++;
      end else if (!a_if_req && fj < 3) begin
        drive(1'b0, 1'b0, 1'b1, 1'b0, f_addr[fj], 64'd0);
        e.data = preset_at(f_addr[fj]); e.cyc = c0 + 4 + 5 * (2 * fj); push(1'b0, 1'b0, e);
        fj++;
      end
      if (a_dm_ack_seen) begin
        a_dm_req = 1'b0;
        ddone++;
      end else if (!a_dm_req && dj < 3) begin
        drive(1'b0, 1'b1, 1'b1, 1'b0, d_addr[dj], 64'd0);
        e.data = preset_at(d_addr[dj]); e.cyc = c0 + 4 + 5 * (2 * dj + 1); push(1'b0, 1'b1, e);
        dj++;
      end
    end
    if (fdone < 3 || ddone < 3) fail_line("cont_timeout");
    a_if_req = 1'b0;
    a_dm_req = 1'b0;
    step();
    a_last_dm = preset_at(d_addr[2]);

    // Isolated transactions from the vector table
    for (int k = 0; k < 8; k++) begin
      v = vecs[k];
      if (v.port && v.we) begin
        run_txn(1'b0, 1'b1, 1'b1, v.addr, v.wdata, a_last_dm, 2);
      end else begin
        run_txn(1'b0, v.port, 1'b0, v.addr, 64'd0, v.rdata, 4);
        if (v.port) a_last_dm = v.rdata;
      end
    end

    // Reset during WAIT of a load: async clear, no ack afterwards
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 64'd0);
    step();
    step();
    #2 RST_N = 1'b0;
    #1 chk_rst(1'b0, "rst_in_wait");
    a_dm_req = 1'b0;
    step();
    step();
    RST_N = 1'b1;
    step();

    // Reset during a store ISSUE: mem_we must drop without waiting for a clock
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h90, 64'h1234_5678_9ABC_DEF0);
    step();
    chk("rst_st_issue_we", 64'(a_mem_we), 64'd1);
    #2 RST_N = 1'b0;
    #1 chk("rst_st_we_drop", 64'(a_mem_we), 64'd0);
    a_dm_req = 1'b0;
    step();
    RST_N = 1'b1;
    step();
    run_txn(1'b0, 1'b0, 1'b0, 32'h10, 64'd0, preset_at(32'h10), 4);

    // MEM_LAT=1: load with dm_addr changed while in flight
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 64'd0);
    e.data = preset_at(32'h40); e.cyc = cyc + 3; push(1'b1, 1'b1, e);
    step();
    chk("b_issue_re", 64'(b_mem_re), 64'd1);
    chk("b_issue_addr", 64'(b_mem_addr), 64'h40);
    step();
    b_dm_addr  = 32'hF8;
    b_dm_wdata = 64'hFFFF_0000_FFFF_0000;
    chk("b_wait_addr_hold", 64'(b_mem_addr), 64'h40);
    step();
    chk("b_ack_addr_hold", 64'(b_mem_addr), 64'h40);
    chk("b_ack_pulse", 64'(b_dm_ack), 64'd1);
    step();
    b_dm_req = 1'b0;
    b_last_dm = preset_at(32'h40);
    run_txn(1'b1, 1'b0, 1'b0, 32'h10, 64'd0, preset_at(32'h10), 3);
    run_txn(1'b1, 1'b1, 1'b1, 32'h20, 64'h0BAD_CAFE_1357_2468, b_last_dm, 2);
    run_txn(1'b1, 1'b1, 1'b0, 32'h20, 64'd0, 64'h0BAD_CAFE_1357_2468, 3);
    repeat (3) step();

    chk("a_if_q_drained", 64'(a_if_q.size()), 64'd0);
    chk("a_dm_q_drained", 64'(a_dm_q.size()), 64'd0);
    chk("b_if_q_drained", 64'(b_if_q.size()), 64'd0);
    chk("b_dm_q_drained", 64'(b_dm_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
